// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised 3R/1W register file with issue scoreboard
// Busy bits are set by reservations and cleared by writeback; reads bypass the in-flight write.
module register_file_sb #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire [WIDTH-1:0]   bus_a,
  inout  wire [WIDTH-1:0]   bus_b,
  inout  wire [WIDTH-1:0]   bus_d,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic              en_a,
  input  logic              en_b,
  input  logic              en_d,
  output logic              rdy_a,
  output logic              rdy_b,
  output logic              rdy_d,
  input  logic [WIDTH-1:0]  bus_w,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic              en_w,
  input  logic [ADDR_W-1:0] addr_r,
  input  logic              en_r,
  output logic [ADDR_W:0]   busy_count,
  output logic              hazard
);

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   count_next;
  logic              wr_ok;
  logic              rsv_ok;
  logic              hazard_next;
  logic [ADDR_W-1:0] rd_addr [3];
  logic [WIDTH-1:0]  rd_data [3];
  logic [2:0]        rd_rdy;

  assign rd_addr[0] = addr_a;
  assign rd_addr[1] = addr_b;
  assign rd_addr[2] = addr_d;

  // A hardwired r0 swallows writes and reservations before they reach any state.
  always_comb begin
    wr_ok     = en_w && !(ZERO_R0 != 0 && addr_w == '0);
    rsv_ok    = en_r && !(ZERO_R0 != 0 && addr_r == '0);
    busy_next = busy;
    if (wr_ok)
      busy_next[addr_w] = 1'b0;
    if (rsv_ok)
      busy_next[addr_r] = 1'b1;
    hazard_next = rsv_ok && busy[addr_r] && !(wr_ok && addr_w == addr_r);
    count_next  = '0;
    for (int i = 0; i < DEPTH; i++)
      count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_rdy[p]  = !busy[rd_addr[p]];
      if (ZERO_R0 != 0 && rd_addr[p] == '0) begin
        rd_data[p] = '0;
        rd_rdy[p]  = 1'b1;
      end else if (BYPASS != 0 && en_w && addr_w == rd_addr[p]) begin
        rd_data[p] = bus_w;
        rd_rdy[p]  = 1'b1;
      end
    end
  end

  assign rdy_a = rd_rdy[0];
  assign rdy_b = rd_rdy[1];
  assign rdy_d = rd_rdy[2];

  // Stale data is still driven while not ready; consumers gate on rdy_x.
  assign bus_a = en_a ? rd_data[0] : {WIDTH{1'bz}};
  assign bus_b = en_b ? rd_data[1] : {WIDTH{1'bz}};
  assign bus_d = en_d ? rd_data[2] : {WIDTH{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
      hazard     <= 1'b0;
    end else begin
      if (wr_ok)
        regs[addr_w] <= bus_w;
      busy       <= busy_next;
      busy_count <= count_next;
      hazard     <= hazard_next;
    end
  end

endmodule
